// File: rtl/repetition_pkg.sv
// Shared framing definitions for the repetition-coded serial link.
// The receive side imports the same package so line levels always agree.
package repetition_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rep_symbol_timer.sv
// Copy counter: counts baud_en pulses and flags the final copy of a symbol.
// sym_last is combinational so the symbol advances on the same edge that
// completes its REPEAT-th copy.
module rep_symbol_timer
    import repetition_pkg::*;
#(
    parameter int REPEAT = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic baud_en,
    input  logic clear,
    output logic sym_last
);

    localparam int CW = cnt_w(REPEAT);
    localparam logic [CW-1:0] LAST_COPY = CW'(REPEAT - 1);

    logic [CW-1:0] rep_cnt;

    assign sym_last = baud_en && !clear && (rep_cnt == LAST_COPY);

    // Copy count: held at zero while cleared, wraps to zero on the last copy.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rep_cnt <= '0;
        end else if (baud_en) begin
            rep_cnt <= sym_last ? '0 : rep_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/repetition_tx.sv
// Repetition-coded serial transmitter.
// Valid/ready handshake: a word transfers on a rising edge where in_valid and
// in_ready are both 1; in_ready depends only on state (and rst), never on
// in_valid. The frame is start, DATA_W data bits LSB first, stop, with each
// symbol driven for REPEAT copies paced by baud_en.
module repetition_tx
    import repetition_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REPEAT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_en,
    input  logic [DATA_W-1:0] in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              busy,
    output logic              done
);

    if (REPEAT < 3 || REPEAT > 15 || (REPEAT % 2) == 0) begin : g_bad_repeat
        $error("repetition_tx: REPEAT must be odd and within 3..15");
    end
    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
        $error("repetition_tx: DATA_W must be within 1..32");
    end

    localparam int BW = cnt_w(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_shift;
    logic [BW-1:0]     bit_cnt;
    logic              sym_last;
    logic              accept;
    logic              last_bit;

    assign in_ready    = (state == IDLE) && !rst;
    assign accept      = in_valid && in_ready;
    assign last_bit    = (bit_cnt == LAST_BIT);
    assign shreg_shift = shreg >> 1;

    // The timer is held clear while idle so START copies count from the
    // first baud_en after acceptance.
    rep_symbol_timer #(
        .REPEAT (REPEAT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .baud_en  (baud_en),
        .clear    (state == IDLE),
        .sym_last (sym_last)
    );

    // Next-state selection; every state advances only on the last copy.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = START;
            START:   if (sym_last) state_next = DATA;
            DATA:    if (sym_last && last_bit) state_next = STOP;
            STOP:    if (sym_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shift register, bit counter and registered line outputs; out always
    // takes the level of the symbol being entered on the advancing edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            out     <= IDLE_LEVEL;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= in;
                        bit_cnt <= '0;
                        out     <= START_LEVEL;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (sym_last) begin
                        bit_cnt <= '0;
                        out     <= shreg[0];
                    end
                end
                DATA: begin
                    if (sym_last) begin
                        if (last_bit) begin
                            out <= STOP_LEVEL;
                        end else begin
                            shreg   <= shreg_shift;
                            bit_cnt <= bit_cnt + 1'b1;
                            out     <= shreg_shift[0];
                        end
                    end
                end
                STOP: begin
                    if (sym_last) begin
                        out  <= IDLE_LEVEL;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: begin
                    out  <= IDLE_LEVEL;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_repetition_tx.sv
// Directed bench for repetition_tx: default instance (DATA_W=8, REPEAT=7)
// plus a small instance (DATA_W=4, REPEAT=3) sharing the clock.
module tb_repetition_tx;

    localparam int DW  = 8;
    localparam int REP = 7;

    // Clock and reset signals
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          baud_en;
    logic [DW-1:0] din;
    logic          in_valid;
    logic          in_ready;
    logic          out_s;
    logic          busy;
    logic          done;

    logic          s_baud;
    logic [3:0]    s_in;
    logic          s_valid;
    logic          s_ready;
    logic          s_out;
    logic          s_busy;
    logic          s_done;

    int vectors     = 0;
    int miscompares = 0;

    logic [0:0] copies[$];
    logic [0:0] exp_q[$];

    repetition_tx #(
        .DATA_W (DW),
        .REPEAT (REP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_en  (baud_en),
        .in       (din),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out      (out_s),
        .busy     (busy),
        .done     (done)
    );

    repetition_tx #(
        .DATA_W (4),
        .REPEAT (3)
    ) dut_small (
        .clk      (clk),
        .rst      (rst),
        .baud_en  (s_baud),
        .in       (s_in),
        .in_valid (s_valid),
        .in_ready (s_ready),
        .out      (s_out),
        .busy     (s_busy),
        .done     (s_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a word to an idle DUT and step across the accepting edge.
    task automatic accept_word(input logic [DW-1:0] w, input int period);
        check("ready_before_accept", in_ready, 1);
        din      = w;
        in_valid = 1'b1;
        baud_en  = (period == 1);
        tick();
        check("busy_after_accept", busy, 1);
        check("out_start_level", out_s, 0);
    endtask

    // Drive baud_en every period cycles and record the line level on each
    // counted copy until done. Optionally keep a side word valid meanwhile.
    task automatic run_frame(input int period, input bit side_valid, input logic [DW-1:0] side_word,
                             input bit keep_valid, output int cycles);
        int   k;
        bit   b;
        logic prev;
        k = 0;
        copies.delete();
        in_valid = side_valid;
        if (side_valid) din = side_word;
        while (done !== 1'b1 && k < 4000) begin
            b = (((k + 1) % period) == (1 % period));
            if (b) copies.push_back(out_s);
            prev    = out_s;
            baud_en = b;
            tick();
            k++;
            if (!b) check("stall_hold", out_s, prev);
        end
        cycles = k;
        check("done_seen", done, 1);
        check("busy_at_done", busy, 0);
        check("out_at_done", out_s, 1);
        check("ready_at_done", in_ready, 1);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    // Compare recorded copies with the expected frame and majority-decode.
    task automatic verify_frame(input logic [DW-1:0] w, input int period, input int cycles);
        logic [DW-1:0] got;
        int            ones;
        int            idx;
        exp_q.delete();
        for (int r = 0; r < REP; r++) exp_q.push_back(1'b0);
        for (int b = 0; b < DW; b++)
            for (int r = 0; r < REP; r++) exp_q.push_back(w[b]);
        for (int r = 0; r < REP; r++) exp_q.push_back(1'b1);
        check("copy_count", copies.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < copies.size(); i++)
            check("copy_value", copies[i], exp_q[i]);
        got = '0;
        for (int b = 0; b < DW; b++) begin
            ones = 0;
            for (int r = 0; r < REP; r++) begin
                idx = (b + 1) * REP + r;
                if (idx < copies.size() && copies[idx] == 1'b1) ones++;
            end
            got[b] = (ones > REP / 2);
        end
        check("vote_word", got, w);
        check("frame_cycles", cycles, 1 + ((DW + 2) * REP - 1) * period);
    endtask

    // Directed sequence
    initial begin
        int            cyc;
        int            k;
        logic [17:0]   s_exp;

        rst = 1'b1; baud_en = 1'b0; in_valid = 1'b0; din = '0;
        s_baud = 1'b0; s_valid = 1'b0; s_in = '0;

        // Reset behaviour
        @(negedge clk);
        check("ready_in_reset", in_ready, 0);
        tick();
        check("reset_out", out_s, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ready", in_ready, 0);
        check("small_reset_out", s_out, 1);
        rst = 1'b0;
        baud_en = 1'b1;

        // Idle with baud running and nothing valid
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_state", {out_s, in_ready, busy, done}, 4'b1100);
        end

        // 8'hA5 at full baud rate
        accept_word(8'hA5, 1);
        run_frame(1, 1'b0, '0, 1'b0, cyc);
        verify_frame(8'hA5, 1, cyc);
        tick();
        check("done_one_cycle", done, 0);
        check("idle_after_a5", {out_s, busy}, 2'b10);

        // 8'h3C with baud every third cycle; in changes to FF while busy
        accept_word(8'h3C, 3);
        run_frame(3, 1'b1, 8'hFF, 1'b0, cyc);
        verify_frame(8'h3C, 3, cyc);
        tick();
        check("ff_not_captured", busy, 0);
        check("ready_after_3c", in_ready, 1);

        // Back-to-back 8'h01 then 8'h80 with valid held high
        accept_word(8'h01, 1);
        run_frame(1, 1'b1, 8'h80, 1'b1, cyc);
        verify_frame(8'h01, 1, cyc);
        tick();
        check("b2b_second_start", out_s, 0);
        check("b2b_second_busy", busy, 1);
        check("b2b_done_cleared", done, 0);
        run_frame(1, 1'b0, '0, 1'b0, cyc);
        verify_frame(8'h80, 1, cyc);
        tick();
        check("b2b_no_duplicate", {out_s, busy}, 2'b10);

        // Reset in the middle of data bit 3 of 8'hC3
        accept_word(8'hC3, 1);
        for (int i = 0; i < 30; i++) begin
            baud_en = 1'b1;
            tick();
        end
        check("mid_frame_busy", busy, 1);
        check("mid_frame_bit3", out_s, 0);
        rst = 1'b1;
        tick();
        check("abort_out", out_s, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ready", in_ready, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_abort_idle", {out_s, busy, done}, 3'b100);
        end
        accept_word(8'h5A, 1);
        run_frame(1, 1'b0, '0, 1'b0, cyc);
        verify_frame(8'h5A, 1, cyc);

        // Small instance: REPEAT=3, DATA_W=4, word 0110
        s_exp = 18'b111_000_111111_000000;
        check("small_ready", s_ready, 1);
        s_in = 4'b0110;
        s_valid = 1'b1;
        s_baud = 1'b1;
        tick();
        s_valid = 1'b0;
        check("small_busy", s_busy, 1);
        k = 0;
        while (s_done !== 1'b1 && k < 100) begin
            if (k < 18) check("small_copy", s_out, s_exp[k]);
            tick();
            k++;
        end
        check("small_done", s_done, 1);
        check("small_frame_len", k, 18);
        check("small_idle_out", s_out, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/repetition_tx.md
Name: repetition_tx

Overview:
- Serial transmitter for the repetition-coded link whose receive end is the majority-vote decoder.
- Accepts a parallel word over a valid/ready handshake and frames it as start symbol, data symbols (LSB first), then stop symbol.
- Drives every symbol for REPEAT consecutive copies so the far-end voter can outvote single-copy errors.
- Sits between the local data source and the serial line driver; copy rate is paced by a baud enable strobe.

Parameters:
- DATA_W, 8, payload bits per frame (1..32).
- REPEAT, 7, copies per symbol; must be odd, 3..15; elaboration error otherwise.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- baud_en  input  1  copy-rate strobe; one copy advances per cycle with baud_en=1.
- in  input  DATA_W  payload word, sampled at the handshake.
- in_valid  input  1  source has a word.
- in_ready  output  1  block can accept a word.
- out  output  1  registered serial line; idle level 1.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse when the last stop copy completes.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset, at the edge where rst=1:
  - state IDLE, out=1, busy=0, done=0, counters 0, data register 0.
  - in_ready=0 while rst=1.
- in_ready = (state==IDLE) && !rst; combinational from state.
- Accept: edge with in_valid && in_ready. At that edge:
  - latch in into the shift register;
  - state goes to START, out goes to 0, busy goes to 1, rep_cnt=0.
- States and transitions:
  - IDLE -> START on accept.
  - START drives 0; after REPEAT copies -> DATA with bit_cnt=0.
  - DATA drives shreg[0]; after REPEAT copies, shift right one and bit_cnt++. After copy REPEAT of bit DATA_W-1 -> STOP.
  - STOP drives 1; after REPEAT copies -> IDLE with done=1 for one cycle.
- Copy counting:
  - rep_cnt increments only on cycles with baud_en=1.
  - At baud_en && rep_cnt==REPEAT-1, rep_cnt resets to 0 and the symbol advances; out takes the next symbol value at that same edge.
  - The first copy of START counts from the first baud_en after acceptance. The START level may therefore last longer than REPEAT cycles if baud_en is sparse; the downstream voter tolerates this.
- Stalls: baud_en=0 freezes state, counters and out. Stall length is unbounded.
- Frame length with baud_en tied high: (DATA_W+2)*REPEAT cycles from the acceptance edge to the done edge. This is 70 cycles at defaults.
- busy=1 from the acceptance edge until the edge that sets done, inclusive of STOP.
- Back-to-back frames: in IDLE the cycle after done, in_ready=1. A waiting word is accepted on that edge, so there is exactly one idle cycle at out=1 between frames.
- in_valid while busy: ignored; no capture, no side effects. in is sampled only at acceptance; later changes have no effect.
- Reset mid-frame: abort at that edge; out=1, busy=0, no done pulse; the latched word is discarded.
- Counter widths:
  - rep_cnt is $clog2(REPEAT) bits;
  - bit_cnt is $clog2(DATA_W) bits, minimum 1;
  - no wrap beyond the terminal values.

Decomposition:
- Shared package repetition_pkg:
  - state enum {IDLE, START, DATA, STOP};
  - IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1;
  - width helper function for counters.
- The package is shared with the receiver side so framing levels match.
- One sub-module, rep_symbol_timer: counts baud_en pulses to REPEAT and emits a sym_last strobe. Its inputs are clk, rst, baud_en and clear.
- The FSM, shift register and output register stay in repetition_tx.

Test Plan:
- Reset then idle, baud_en=1, no valid -> out=1, in_ready=1, busy=0, done=0 for 50 cycles.
- in=8'hA5, baud_en=1 -> out stream: 7×0, then bits 1,0,1,0,0,1,0,1 each 7 copies, then 7×1. done pulses exactly 70 cycles after acceptance. Feeding every 7-copy group into a majority vote recovers 8'hA5.
- baud_en every 3rd cycle, in=8'h3C -> same symbol sequence, each copy held 3 cycles. Total frame length is 210 cycles ±2. in changed mid-frame to 8'hFF -> still 3C transmitted.
- Two words 8'h01, 8'h80 held valid continuously -> second accepted the cycle after the first done. Exactly one idle-1 cycle separates the frames; no word is lost or duplicated.
- rst asserted in DATA at bit 3 -> out=1 and busy=0 on the next edge, no done. A following frame with 8'h5A transmits correctly.
- REPEAT=3, DATA_W=4, in=4'b0110 -> 3×0, 0,0,0,1,1,1,1,1,1,0,0,0, then 3×1. Frame is 18 cycles.
